// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match controller slice.
package pong_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_RUNNING   = 3'd2,
    S_POINT_P1  = 3'd3,
    S_POINT_P2  = 3'd4,
    S_PAUSED    = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam logic DIR_P1 = 1'b0;
  localparam logic DIR_P2 = 1'b1;

  localparam int DEF_COORD_W   = 12;
  localparam int DEF_SCREEN_W  = 640;
  localparam int DEF_PADDLE_H  = 64;
  localparam int DEF_BALL_SIZE = 8;

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Game-side signal bundle of the match controller (clock and reset stay separate).
interface pong_match_ctrl_if #(
  parameter int COORD_W = 12,
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               pause;
  logic [COORD_W-1:0] x_ball;
  logic [COORD_W-1:0] y_ball;
  logic [COORD_W-1:0] y_paddle1;
  logic [COORD_W-1:0] y_paddle2;
  logic               game_active;
  logic               serve_req;
  logic               serve_dir;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic [2:0]         state_out;

  modport master (
    output frame_tick, start, pause, x_ball, y_ball, y_paddle1, y_paddle2,
    input  game_active, serve_req, serve_dir, p1_score, p2_score, winner, state_out
  );

  modport slave (
    input  frame_tick, start, pause, x_ball, y_ball, y_paddle1, y_paddle2,
    output game_active, serve_req, serve_dir, p1_score, p2_score, winner, state_out
  );
endinterface

// File: rtl/pong_serve_timer.sv
// Counts frame ticks while enabled; done pulses on the DELAY-th tick.
module pong_serve_timer #(
  parameter int DELAY = 60
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic frame_tick,
  output logic done
);
  localparam int EFF   = (DELAY < 1) ? 1 : DELAY;
  localparam int CNT_W = $clog2(EFF) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(EFF - 1);

  logic [CNT_W-1:0] cnt;

  assign done = enable && frame_tick && (cnt == LAST);

  // Tick counter, restarted on clear and after each completed delay.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && frame_tick) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencing for pong: serve timing, miss detection, scoring, pause.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int BALL_SIZE   = DEF_BALL_SIZE,
  parameter int MAX_SCORE   = 5,
  parameter int SCORE_W     = 4,
  parameter int SERVE_DELAY = 60
) (
  input logic              clk_in,
  input logic              reset,
  pong_match_ctrl_if.slave bus
);
  localparam int CW = COORD_W + 1;

  if (MAX_SCORE >= 2**SCORE_W || MAX_SCORE < 1) begin : g_bad_max_score
    $error("MAX_SCORE must be in 1 .. 2**SCORE_W-1");
  end

  state_t             state;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [1:0]         winner;
  logic               serve_req;
  logic               serve_dir;
  logic               start_q;
  logic               start_low_seen;
  logic               start_rise;
  logic               timer_done;

  // A start held through reset must not count as a rise even though start_q
  // restarts at 0, so a rise also requires start to have been seen low since reset.
  assign start_rise = bus.start && !start_q && start_low_seen;

  logic [CW-1:0] y_ball_w, ball_bot, pad1_top, pad1_bot, pad2_top, pad2_bot;
  logic          miss_left, miss_right;

  // Miss comparators, widened one bit so paddle/ball sums cannot wrap.
  always_comb begin
    y_ball_w   = {1'b0, bus.y_ball};
    ball_bot   = y_ball_w + CW'(BALL_SIZE);
    pad1_top   = {1'b0, bus.y_paddle1};
    pad1_bot   = pad1_top + CW'(PADDLE_H);
    pad2_top   = {1'b0, bus.y_paddle2};
    pad2_bot   = pad2_top + CW'(PADDLE_H);
    miss_left  = (bus.x_ball == '0) &&
                 ((ball_bot <= pad1_top) || (y_ball_w >= pad1_bot));
    miss_right = ({1'b0, bus.x_ball} >= CW'(SCREEN_W - BALL_SIZE)) &&
                 ((ball_bot <= pad2_top) || (y_ball_w >= pad2_bot));
  end

  pong_serve_timer #(
    .DELAY(SERVE_DELAY)
  ) u_timer (
    .clk_in    (clk_in),
    .reset     (reset),
    .clear     (state != S_SERVE),
    .enable    ((state == S_SERVE) && !serve_req),
    .frame_tick(bus.frame_tick),
    .done      (timer_done)
  );

  // Match state machine with registered scores, winner and serve controls.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      p1_score       <= '0;
      p2_score       <= '0;
      winner         <= WIN_NONE;
      serve_req      <= 1'b0;
      serve_dir      <= DIR_P2;
      start_q        <= 1'b0;
      start_low_seen <= 1'b0;
    end else begin
      start_q   <= bus.start;
      serve_req <= 1'b0;
      if (!bus.start) start_low_seen <= 1'b1;
      case (state)
        S_IDLE, S_GAME_OVER: begin
          if (start_rise) begin
            p1_score  <= '0;
            p2_score  <= '0;
            winner    <= WIN_NONE;
            serve_dir <= DIR_P2;
            state     <= S_SERVE;
          end
        end
        S_SERVE: begin
          if (serve_req) state <= S_RUNNING;
          else if (timer_done) serve_req <= 1'b1;
        end
        S_RUNNING: begin
          if (miss_left) state <= S_POINT_P2;
          else if (miss_right) state <= S_POINT_P1;
          else if (bus.pause) state <= S_PAUSED;
        end
        S_PAUSED: begin
          if (!bus.pause) state <= S_RUNNING;
        end
        S_POINT_P1: begin
          if (p1_score < SCORE_W'(MAX_SCORE)) p1_score <= p1_score + SCORE_W'(1);
          if (p1_score >= SCORE_W'(MAX_SCORE - 1)) begin
            winner <= WIN_P1;
            state  <= S_GAME_OVER;
          end else begin
            serve_dir <= DIR_P2;
            state     <= S_SERVE;
          end
        end
        S_POINT_P2: begin
          if (p2_score < SCORE_W'(MAX_SCORE)) p2_score <= p2_score + SCORE_W'(1);
          if (p2_score >= SCORE_W'(MAX_SCORE - 1)) begin
            winner <= WIN_P2;
            state  <= S_GAME_OVER;
          end else begin
            serve_dir <= DIR_P1;
            state     <= S_SERVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.game_active = (state == S_RUNNING);
  assign bus.state_out   = state;
  assign bus.serve_req   = serve_req;
  assign bus.serve_dir   = serve_dir;
  assign bus.p1_score    = p1_score;
  assign bus.p2_score    = p2_score;
  assign bus.winner      = winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: miss-detection vector table plus match sequences.
module tb_pong_match_ctrl;
  import pong_pkg::*;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 clk_in = ~clk_in;

  pong_match_ctrl_if #(.COORD_W(12), .SCORE_W(4)) bus ();

  pong_match_ctrl #(
    .COORD_W    (12),
    .SCREEN_W   (640),
    .PADDLE_H   (64),
    .BALL_SIZE  (8),
    .MAX_SCORE  (5),
    .SCORE_W    (4),
    .SERVE_DELAY(3)
  ) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] xb;
    logic [11:0] yb;
    logic [11:0] p1;
    logic [11:0] p2;
    logic [2:0]  exp_state;
    logic        exp_dir;
    int          exp_p1;
    int          exp_p2;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic safe_ball();
    bus.x_ball    = 12'd300;
    bus.y_ball    = 12'd200;
    bus.y_paddle1 = 12'd200;
    bus.y_paddle2 = 12'd200;
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
  endtask

  // Three frame ticks separated by idle cycles; serve_req on the third, RUNNING after.
  task automatic serve();
    for (int i = 0; i < 3; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      chk("serve_req_on_tick", int'(bus.serve_req), (i == 2) ? 1 : 0);
      if (i == 2) chk("not_active_during_serve_req", int'(bus.game_active), 0);
      if (i < 2) step();
    end
    step();
    chk("active_after_serve", int'(bus.game_active), 1);
    chk("serve_req_cleared", int'(bus.serve_req), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{12'd0,   12'd40,   12'd100,  12'd200, 3'(S_POINT_P2), 1'b0, 0, 1};
    vecs[1]  = '{12'd0,   12'd100,  12'd100,  12'd200, 3'(S_RUNNING),  1'b1, 0, 0};
    vecs[2]  = '{12'd0,   12'd164,  12'd100,  12'd200, 3'(S_POINT_P2), 1'b0, 0, 1};
    vecs[3]  = '{12'd0,   12'd92,   12'd100,  12'd200, 3'(S_POINT_P2), 1'b0, 0, 1};
    vecs[4]  = '{12'd0,   12'd93,   12'd100,  12'd200, 3'(S_RUNNING),  1'b1, 0, 0};
    vecs[5]  = '{12'd0,   12'd163,  12'd100,  12'd200, 3'(S_RUNNING),  1'b1, 0, 0};
    vecs[6]  = '{12'd632, 12'd40,   12'd200,  12'd100, 3'(S_POINT_P1), 1'b1, 1, 0};
    vecs[7]  = '{12'd631, 12'd40,   12'd200,  12'd100, 3'(S_RUNNING),  1'b1, 0, 0};
    vecs[8]  = '{12'd700, 12'd120,  12'd200,  12'd100, 3'(S_RUNNING),  1'b1, 0, 0};
    vecs[9]  = '{12'd0,   12'd4095, 12'd4050, 12'd200, 3'(S_RUNNING),  1'b1, 0, 0};
    vecs[10] = '{12'd0,   12'd4000, 12'd4090, 12'd200, 3'(S_POINT_P2), 1'b0, 0, 1};

    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    safe_ball();

    // Reset values, checked while reset is asserted.
    reset = 1'b1;
    #7;
    chk("rst_state", int'(bus.state_out), int'(S_IDLE));
    chk("rst_p1", int'(bus.p1_score), 0);
    chk("rst_p2", int'(bus.p2_score), 0);
    chk("rst_winner", int'(bus.winner), 0);
    chk("rst_serve_req", int'(bus.serve_req), 0);
    chk("rst_serve_dir", int'(bus.serve_dir), 1);
    chk("rst_active", int'(bus.game_active), 0);
    reset = 1'b0;
    step();
    chk("idle_no_start", int'(bus.state_out), int'(S_IDLE));

    // First serve.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_to_serve", int'(bus.state_out), int'(S_SERVE));
    step();
    serve();
    chk("first_serve_dir", int'(bus.serve_dir), 1);
    chk("running_state", int'(bus.state_out), int'(S_RUNNING));

    // Miss-detection table: each vector from a fresh game in RUNNING.
    for (int v = 0; v < 11; v++) begin
      safe_ball();
      do_reset();
      start_game();
      serve();
      bus.x_ball    = vecs[v].xb;
      bus.y_ball    = vecs[v].yb;
      bus.y_paddle1 = vecs[v].p1;
      bus.y_paddle2 = vecs[v].p2;
      step();
      chk($sformatf("vec%0d_state", v), int'(bus.state_out), int'(vecs[v].exp_state));
      safe_ball();
      step();
      if (vecs[v].exp_state == 3'(S_RUNNING))
        chk($sformatf("vec%0d_hold", v), int'(bus.state_out), int'(S_RUNNING));
      else
        chk($sformatf("vec%0d_to_serve", v), int'(bus.state_out), int'(S_SERVE));
      chk($sformatf("vec%0d_p1", v), int'(bus.p1_score), vecs[v].exp_p1);
      chk($sformatf("vec%0d_p2", v), int'(bus.p2_score), vecs[v].exp_p2);
      chk($sformatf("vec%0d_dir", v), int'(bus.serve_dir), int'(vecs[v].exp_dir));
    end

    // P1 wins five straight points.
    safe_ball();
    do_reset();
    start_game();
    for (int i = 0; i < 5; i++) begin
      serve();
      bus.x_ball    = 12'd632;
      bus.y_ball    = 12'd40;
      bus.y_paddle2 = 12'd100;
      step();
      chk("win_point_state", int'(bus.state_out), int'(S_POINT_P1));
      safe_ball();
      step();
      chk("win_p1_score", int'(bus.p1_score), i + 1);
      if (i < 4) begin
        chk("win_back_to_serve", int'(bus.state_out), int'(S_SERVE));
        chk("win_serve_dir", int'(bus.serve_dir), 1);
      end
    end
    chk("game_over_state", int'(bus.state_out), int'(S_GAME_OVER));
    chk("game_over_winner", int'(bus.winner), 1);
    bus.pause      = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    step();
    bus.pause      = 1'b0;
    bus.frame_tick = 1'b0;
    chk("game_over_hold", int'(bus.state_out), int'(S_GAME_OVER));
    chk("game_over_score_hold", int'(bus.p1_score), 5);
    chk("game_over_no_serve", int'(bus.serve_req), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_state", int'(bus.state_out), int'(S_SERVE));
    chk("restart_p1", int'(bus.p1_score), 0);
    chk("restart_winner", int'(bus.winner), 0);
    chk("restart_dir", int'(bus.serve_dir), 1);

    // Pause behaviour.
    step();
    serve();
    bus.pause = 1'b1;
    step();
    chk("paused_state", int'(bus.state_out), int'(S_PAUSED));
    chk("paused_inactive", int'(bus.game_active), 0);
    bus.x_ball    = 12'd0;
    bus.y_ball    = 12'd40;
    bus.y_paddle1 = 12'd100;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("paused_no_score", int'(bus.p2_score), 0);
    chk("paused_ignores_start", int'(bus.state_out), int'(S_PAUSED));
    safe_ball();
    bus.pause = 1'b0;
    step();
    chk("unpause_running", int'(bus.state_out), int'(S_RUNNING));
    bus.pause     = 1'b1;
    bus.x_ball    = 12'd0;
    bus.y_ball    = 12'd40;
    bus.y_paddle1 = 12'd100;
    step();
    chk("miss_beats_pause", int'(bus.state_out), int'(S_POINT_P2));
    safe_ball();
    step();
    chk("miss_pause_p2", int'(bus.p2_score), 1);
    chk("miss_pause_serve", int'(bus.state_out), int'(S_SERVE));
    step();
    chk("pause_ignored_in_serve", int'(bus.state_out), int'(S_SERVE));
    bus.pause = 1'b0;

    // Reset in SERVE with start held high, at the cycle serve_req would fire.
    safe_ball();
    do_reset();
    start_game();
    bus.frame_tick = 1'b1;
    step();
    step();
    bus.start = 1'b1;
    reset     = 1'b1;
    step();
    chk("midserve_reset_state", int'(bus.state_out), int'(S_IDLE));
    chk("midserve_no_serve_req", int'(bus.serve_req), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_start_idle", int'(bus.state_out), int'(S_IDLE));
      chk("held_start_no_serve", int'(bus.serve_req), 0);
    end
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    step();
    chk("start_low_idle", int'(bus.state_out), int'(S_IDLE));
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("fresh_start_serve", int'(bus.state_out), int'(S_SERVE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameters: COORD_W, default 12, coordinate width; SCREEN_W, default 640, playfield width in pixels; PADDLE_H, default 64, paddle height; BALL_SIZE, default 8, ball edge length; MAX_SCORE, default 5, winning score; SCORE_W, default 4, score width; SERVE_DELAY, default 60, frame ticks before a serve.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk_in, input, 1, the only clock.
- reset, input, 1, asynchronous active-high reset.
- frame_tick, input, 1, one-cycle pulse per video frame.
- start, input, 1, level; only its rising edge is used.
- pause, input, 1, level pause request.
- x_ball, y_ball, input, COORD_W each, ball top-left corner.
- y_paddle1, y_paddle2, input, COORD_W each, paddle tops; paddle1 is on the left, paddle2 on the right.
- game_active, output, 1, high only in RUNNING.
- serve_req, output, 1, one-cycle pulse that launches the ball.
- serve_dir, output, 1, direction of the next serve: 0 = toward P1 (left), 1 = toward P2 (right).
- p1_score, p2_score, output, SCORE_W each, player scores.
- winner, output, 2, 00 none, 01 P1, 10 P2.
- state_out, output, 3, current state encoding.

Function
REQ-003 SHALL implement the states IDLE, SERVE, RUNNING, POINT_P1, POINT_P2, PAUSED and GAME_OVER.
REQ-004 SHALL register start and treat start_rise = start AND NOT start_q as the only start event.
REQ-005 IDLE: on start_rise, SHALL clear both scores and winner, set serve_dir=1, and go to SERVE.
REQ-006 SERVE: SHALL count frame_tick pulses from 0; when the count reaches SERVE_DELAY-1 and frame_tick is high, SHALL pulse serve_req for exactly one cycle and enter RUNNING on the next cycle. SERVE_DELAY=0 SHALL be treated as 1.
REQ-007 RUNNING, left miss: x_ball==0 AND (y_ball+BALL_SIZE <= y_paddle1 OR y_ball >= y_paddle1+PADDLE_H) SHALL cause a transition to POINT_P2.
REQ-008 RUNNING, right miss: x_ball >= SCREEN_W-BALL_SIZE AND the same test against y_paddle2 SHALL cause a transition to POINT_P1.
REQ-009 If both misses are true in the same cycle, the left miss SHALL take priority.
REQ-010 All paddle sums SHALL be computed at COORD_W+1 bits, so they never wrap.
REQ-011 A ball that touches a wall inside the paddle span SHALL NOT score. Bounce handling is not part of this block.
REQ-012 RUNNING with pause high and no miss in that cycle SHALL go to PAUSED. A miss in the same cycle SHALL take priority over pause.
REQ-013 PAUSED: SHALL hold scores and the serve counter, keep game_active=0, and return to RUNNING when pause goes low. start_rise SHALL be ignored in PAUSED.
REQ-014 POINT_Px: SHALL last exactly one cycle and increment the scorer's score by 1.
- If the new score equals MAX_SCORE: set winner and go to GAME_OVER.
- Otherwise: set serve_dir toward the conceding player and go to SERVE with the counter cleared.
REQ-015 Scores SHALL never exceed MAX_SCORE. Elaboration SHALL fail if MAX_SCORE >= 2**SCORE_W.
REQ-016 GAME_OVER: SHALL hold scores and winner. On start_rise, SHALL clear scores and winner, set serve_dir=1, and go to SERVE, i.e. behave as IDLE+start.
REQ-017 pause SHALL have no effect outside RUNNING and PAUSED.
REQ-018 game_active and state_out SHALL be decoded from the state register with no added latency.

Reset
REQ-019 reset high SHALL asynchronously force: state IDLE, p1_score=0, p2_score=0, winner=00, serve_req=0, serve_dir=1, serve counter 0, start_q=0.
REQ-020 Reset asserted mid-rally or mid-serve SHALL abort the rally or serve with no serve_req pulse. After release, the block SHALL wait in IDLE for a fresh start_rise; a start held high through reset SHALL NOT start a game.

Structure
REQ-021 Shared package pong_pkg SHALL hold: the state enum (3-bit), the winner codes, the serve_dir codes, and the default values for SCREEN_W, PADDLE_H, BALL_SIZE and COORD_W.
REQ-022 The serve timer SHALL be a sub-module pong_serve_timer with ports clk_in, reset, clear, enable, frame_tick, done; done is a one-cycle pulse.
REQ-023 The miss comparators SHALL stay in pong_match_ctrl as combinational logic.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then start_rise, SERVE_DELAY=3: serve_req pulses on the 3rd frame_tick; game_active rises the next cycle; serve_dir=1.
- RUNNING, y_paddle1=100, x_ball=0, y_ball=40: POINT_P2 for 1 cycle, p2_score=1, serve_dir=0, state SERVE.
- x_ball=0, y_ball=100, y_paddle1=100: no score. y_ball=164: score. y_ball=92: score, because 92+8 <= 100.
- P1 wins five consecutive points with MAX_SCORE=5: p1_score=5, winner=01, GAME_OVER; start_rise then gives p1_score=0 and state SERVE.
- pause raised in RUNNING: PAUSED, game_active=0, no scoring; pause dropped: RUNNING. A miss and pause in the same cycle: the point is scored.
- reset pulsed in SERVE while start is held high: IDLE, no serve_req, and the state stays IDLE until start falls and rises again.
